// File: rtl/writeback_unit.sv
// Writeback stage: stage register with branch-tag squash plus a PASS/WAIT_LOAD/WRITE load FSM.
// Optional load timeout (adds the load_err port) is enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_in,
   input  logic [6:0]  opcode_in,
   input  logic [3:0]  rd_in,
   input  logic        branch_in,
   input  logic        branch_ref,
   input  logic        sel_stall,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [31:0] instr_output,
   output logic [3:0]  rd,
   output logic        stall_req,
   output logic        w_en2,
   output logic [3:0]  w_addr2,
   output logic [31:0] w_data2,
   output logic        load_pc_wb
`ifdef WB_LOAD_TIMEOUT_EN
   ,
   output logic        load_err
`endif
);

   typedef enum logic [1:0] {PASS, WAIT_LOAD, WRITE} state_t;

   state_t      state_q;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [3:0]  rd_q, rd_d;
   logic [31:0] data_q;
   logic [3:0]  waddr_q;
   logic        wen_q;
   logic        pc_q;
   logic        capture;
   logic        load_d;

`ifdef WB_LOAD_TIMEOUT_EN
   logic [3:0]  wait_cnt_q;
   logic        err_q;
`endif

   assign stall_req = (state_q == WAIT_LOAD);
   assign capture   = !sel_stall && !stall_req;

   always_comb begin
      valid_d  = valid_q;
      instr_d  = instr_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      if (capture) begin
         valid_d  = (branch_in == branch_ref);
         instr_d  = instr_in;
         opcode_d = opcode_in;
         rd_d     = rd_in;
      end
   end

   // Load class: 110xxxx or 1000xxx, and only for a non-squashed capture.
   assign load_d = capture && valid_d && !opcode_d[4] &&
                   ((opcode_d[6:5] == 2'b11) || (opcode_d[6:3] == 4'b1000));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         instr_q  <= '0;
         opcode_q <= '0;
         rd_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PASS;
         data_q  <= '0;
         waddr_q <= '0;
         wen_q   <= 1'b0;
         pc_q    <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         // Write-port registers are single-cycle pulses; they hold 0 unless entering WRITE.
         data_q  <= '0;
         waddr_q <= '0;
         wen_q   <= 1'b0;
         pc_q    <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
         case (state_q)
            PASS, WRITE: begin
               if (load_d) begin
                  state_q <= WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
                  wait_cnt_q <= '0;
`endif
               end else begin
                  state_q <= PASS;
               end
            end
            WAIT_LOAD: begin
               if (mem_rvalid) begin
                  state_q <= WRITE;
                  data_q  <= mem_rdata;
                  waddr_q <= rd_q;
                  wen_q   <= 1'b1;
                  pc_q    <= (rd_q == 4'hF);
               end
`ifdef WB_LOAD_TIMEOUT_EN
               else if (wait_cnt_q == 4'd14) begin
                  state_q    <= PASS;
                  wait_cnt_q <= 4'd15;
                  err_q      <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 4'd1;
               end
`endif
            end
            default: state_q <= PASS;
         endcase
      end
   end

   assign instr_output = valid_q ? instr_q : 32'h0;
   assign rd           = rd_q;
   assign w_en2        = wen_q;
   assign w_addr2      = waddr_q;
   assign w_data2      = data_q;
   assign load_pc_wb   = pc_q;
`ifdef WB_LOAD_TIMEOUT_EN
   assign load_err     = err_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed literal cases plus randomized traffic against a behavioural model.
module tb_writeback_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr_in;
   logic [6:0]  opcode_in;
   logic [3:0]  rd_in;
   logic        branch_in;
   logic        branch_ref;
   logic        sel_stall;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic [31:0] instr_output;
   logic [3:0]  rd;
   logic        stall_req;
   logic        w_en2;
   logic [3:0]  w_addr2;
   logic [31:0] w_data2;
   logic        load_pc_wb;
`ifdef WB_LOAD_TIMEOUT_EN
   logic        load_err;
`endif

   int checks = 0;
   int failures = 0;
   bit chk_en = 0;

   writeback_unit dut (
      .clk(clk), .rst_n(rst_n),
      .instr_in(instr_in), .opcode_in(opcode_in), .rd_in(rd_in),
      .branch_in(branch_in), .branch_ref(branch_ref), .sel_stall(sel_stall),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .instr_output(instr_output), .rd(rd), .stall_req(stall_req),
      .w_en2(w_en2), .w_addr2(w_addr2), .w_data2(w_data2),
      .load_pc_wb(load_pc_wb)
`ifdef WB_LOAD_TIMEOUT_EN
      , .load_err(load_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: a load is "outstanding" from its capture until data arrives.
   function automatic bit is_load_op(input logic [6:0] op);
      return ((op >> 4) == 7'd6) || ((op >> 3) == 7'd8);
   endfunction

   bit        m_valid, m_wait, m_wr, m_err;
   bit [31:0] m_instr, m_wd;
   bit [3:0]  m_rd, m_wa;
   int        m_waited;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_wait = 0; m_wr = 0; m_err = 0;
         m_instr = 0; m_wd = 0; m_rd = 0; m_wa = 0; m_waited = 0;
      end else begin
         m_wr = 0; m_wa = 0; m_wd = 0; m_err = 0;
         if (m_wait) begin
            if (mem_rvalid) begin
               m_wr = 1; m_wa = m_rd; m_wd = mem_rdata; m_wait = 0;
            end
`ifdef WB_LOAD_TIMEOUT_EN
            else begin
               m_waited++;
               if (m_waited == 15) begin
                  m_wait = 0; m_err = 1;
               end
            end
`endif
         end else if (!sel_stall) begin
            m_instr = instr_in;
            m_rd    = rd_in;
            m_valid = (branch_in == branch_ref);
            if (m_valid && is_load_op(opcode_in)) begin
               m_wait = 1; m_waited = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("instr_output", instr_output, m_valid ? m_instr : 32'h0);
         check("rd", {28'h0, rd}, {28'h0, m_rd});
         check("stall_req", {31'h0, stall_req}, {31'h0, m_wait});
         check("w_en2", {31'h0, w_en2}, {31'h0, m_wr});
         check("w_addr2", {28'h0, w_addr2}, {28'h0, m_wa});
         check("w_data2", w_data2, m_wd);
         check("load_pc_wb", {31'h0, load_pc_wb}, {31'h0, (m_wr && m_wa == 4'hF)});
`ifdef WB_LOAD_TIMEOUT_EN
         check("load_err", {31'h0, load_err}, {31'h0, m_err});
`endif
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] ins, input logic [6:0] op, input logic [3:0] r,
                        input logic br, input logic rv, input logic [31:0] rdat);
      instr_in = ins; opcode_in = op; rd_in = r; branch_in = br; branch_ref = 1'b0;
      sel_stall = 1'b0; mem_rvalid = rv; mem_rdata = rdat;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_instr"}, instr_output, 32'h0);
      check({tag, "_stall"}, {31'h0, stall_req}, 32'h0);
      check({tag, "_wen"}, {31'h0, w_en2}, 32'h0);
      check({tag, "_wdata"}, w_data2, 32'h0);
      check({tag, "_rd"}, {28'h0, rd}, 32'h0);
   endtask

   localparam logic [6:0] OP_ALU  = 7'h33;
   localparam logic [6:0] OP_LOAD = 7'h60;

   initial begin
      rst_n = 1'b0;
      drive(32'h0, 7'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      cyc(); cyc();
      check_all_zero("reset");
      rst_n = 1'b1;
      chk_en = 1;

      // ALU pass-through
      drive(32'h12345678, OP_ALU, 4'h5, 1'b0, 1'b0, 32'h0);
      cyc();
      check("alu_instr", instr_output, 32'h12345678);
      check("alu_wen", {31'h0, w_en2}, 32'h0);

      // Squashed load: no wait state
      drive(32'hCAFE0001, OP_LOAD, 4'h4, 1'b1, 1'b0, 32'h0);
      cyc();
      check("squash_instr", instr_output, 32'h0);
      check("squash_stall", {31'h0, stall_req}, 32'h0);

      // Load rd=3, two wait cycles, data on the second
      drive(32'hA5A50003, OP_LOAD, 4'h3, 1'b0, 1'b0, 32'h0);
      cyc();
      check("ld3_stall1", {31'h0, stall_req}, 32'h1);
      instr_in = 32'h11111111;
      cyc();
      check("ld3_stall2", {31'h0, stall_req}, 32'h1);
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      cyc();
      check("ld3_wen", {31'h0, w_en2}, 32'h1);
      check("ld3_waddr", {28'h0, w_addr2}, 32'h3);
      check("ld3_wdata", w_data2, 32'hDEADBEEF);
      check("ld3_held_instr", instr_output, 32'hA5A50003);
      check("ld3_stall_off", {31'h0, stall_req}, 32'h0);
      drive(32'h22222222, OP_ALU, 4'h1, 1'b0, 1'b1, 32'h0BADF00D);
      cyc();
      check("ld3_one_cycle", {31'h0, w_en2}, 32'h0);
      check("ld3_data_clr", w_data2, 32'h0);

      // Load to r15 with immediate data; a new load captured on the WRITE edge
      drive(32'hF0F0000F, OP_LOAD, 4'hF, 1'b0, 1'b0, 32'h0);
      cyc();
      mem_rvalid = 1'b1; mem_rdata = 32'h00001000;
      cyc();
      check("pc_load_pc_wb", {31'h0, load_pc_wb}, 32'h1);
      check("pc_waddr", {28'h0, w_addr2}, 32'hF);
      drive(32'h00000002, 7'h40, 4'h2, 1'b0, 1'b0, 32'h0);
      cyc();
      check("b2b_stall", {31'h0, stall_req}, 32'h1);
      check("b2b_pc_clr", {31'h0, load_pc_wb}, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h76543210;
      cyc();
      check("b2b_waddr", {28'h0, w_addr2}, 32'h2);
      check("b2b_wdata", w_data2, 32'h76543210);

      // Reset during WAIT_LOAD aborts the load
      drive(32'h77770007, OP_LOAD, 4'h7, 1'b0, 1'b0, 32'h0);
      cyc();
      check("rst_pre_stall", {31'h0, stall_req}, 32'h1);
      #1 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      #1 rst_n = 1'b1;
      drive(32'h33333333, OP_ALU, 4'h7, 1'b0, 1'b1, 32'h99999999);
      cyc();
      check("rst_no_write", {31'h0, w_en2}, 32'h0);
      check("rst_no_stall", {31'h0, stall_req}, 32'h0);

      // Long wait: indefinite by default, timeout when enabled
      drive(32'h88880008, OP_LOAD, 4'h8, 1'b0, 1'b0, 32'h0);
      cyc();
`ifdef WB_LOAD_TIMEOUT_EN
      repeat (14) cyc();
      check("to_stall15", {31'h0, stall_req}, 32'h1);
      cyc();
      check("to_err", {31'h0, load_err}, 32'h1);
      check("to_stall_drop", {31'h0, stall_req}, 32'h0);
      check("to_no_write", {31'h0, w_en2}, 32'h0);
      drive(32'h0, OP_ALU, 4'h0, 1'b0, 1'b0, 32'h0);
      cyc();
      check("to_err_pulse", {31'h0, load_err}, 32'h0);
`else
      repeat (20) cyc();
      check("long_wait_stall", {31'h0, stall_req}, 32'h1);
      mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
      cyc();
      check("long_wait_wdata", w_data2, 32'h5A5A5A5A);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         instr_in   = $urandom;
         opcode_in  = ($urandom_range(0, 2) == 0) ? 7'($urandom) :
                      (($urandom_range(0, 1) == 0) ? 7'(7'h60 | ($urandom & 7'h0F)) : 7'(7'h40 | ($urandom & 7'h07)));
         rd_in      = 4'($urandom);
         branch_ref = 1'($urandom);
         branch_in  = ($urandom_range(0, 4) == 0) ? ~branch_ref : branch_ref;
         sel_stall  = ($urandom_range(0, 4) == 0);
         mem_rvalid = ($urandom_range(0, 2) == 0);
         mem_rdata  = $urandom;
         if ($urandom_range(0, 149) == 0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
